// File: rtl/fu_result_arbiter.sv
// Execute-stage result arbiter: grants one functional unit per cycle into the
// single EX/MEM result slot, with starvation protection for low-priority units.
module fu_result_arbiter #(
  parameter int NUM_UNITS    = 10,
  parameter int DATA_W       = 32,
  parameter int RD_W         = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_UNITS-1:0]        req_valid_i,
  output logic [NUM_UNITS-1:0]        req_ready_o,
  input  logic [NUM_UNITS*DATA_W-1:0] req_result_i,
  input  logic [NUM_UNITS*RD_W-1:0]   req_rd_i,
  input  logic [NUM_UNITS-1:0]        req_fp_i,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic [DATA_W-1:0]           out_result_o,
  output logic [RD_W-1:0]             out_rd_o,
  output logic                        out_fp_o,
  output logic [3:0]                  out_sel_o
);

  localparam logic [3:0] SEL_DEFAULT = 4'd7;
  localparam logic [3:0] LIMIT       = 4'(STARVE_LIMIT);

  // Lowest set index wins: index 0 carries the highest priority.
  function automatic logic [3:0] lowest_idx(input logic [NUM_UNITS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_UNITS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= LIMIT) ? LIMIT : c + 4'd1;
  endfunction

  logic                 out_valid_q, out_valid_d;
  logic [DATA_W-1:0]    out_result_q, out_result_d;
  logic [RD_W-1:0]      out_rd_q, out_rd_d;
  logic                 out_fp_q, out_fp_d;
  logic [3:0]           out_sel_q, out_sel_d;
  logic [3:0]           cnt_q [NUM_UNITS];
  logic [3:0]           cnt_d [NUM_UNITS];

  logic                 can_load;
  logic                 any_grant;
  logic [3:0]           gnt_idx;
  logic [NUM_UNITS-1:0] starved;
  logic [NUM_UNITS-1:0] gnt;
  logic [DATA_W-1:0]    sel_result;
  logic [RD_W-1:0]      sel_rd;
  logic                 sel_fp;

  assign can_load = ~out_valid_q | out_ready_i;

  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      starved[i] = req_valid_i[i] & (cnt_q[i] == LIMIT);
    end
  end

  // Starved requesters pre-empt the fixed priority order.
  always_comb begin
    any_grant = can_load & (|req_valid_i);
    gnt_idx   = (|starved) ? lowest_idx(starved) : lowest_idx(req_valid_i);
    for (int i = 0; i < NUM_UNITS; i++) begin
      gnt[i] = any_grant & (gnt_idx == 4'(i));
    end
  end

  // Ready is masked by reset so nothing handshakes while the slot is being cleared.
  assign req_ready_o = gnt & {NUM_UNITS{reset_n}};

  always_comb begin
    sel_result = '0;
    sel_rd     = '0;
    sel_fp     = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (gnt[i]) begin
        sel_result = req_result_i[i*DATA_W +: DATA_W];
        sel_rd     = req_rd_i[i*RD_W +: RD_W];
        sel_fp     = req_fp_i[i];
      end
    end
  end

  // Backpressure freezes the counters so a stalled pipe is not mistaken for starvation.
  always_comb begin
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (!req_valid_i[i] || gnt[i]) begin
        cnt_d[i] = '0;
      end else if (can_load) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    out_rd_d     = out_rd_q;
    out_fp_d     = out_fp_q;
    out_sel_d    = out_sel_q;
    if (can_load) begin
      out_valid_d = any_grant;
      if (any_grant) begin
        out_result_d = sel_result;
        out_rd_d     = sel_rd;
        out_fp_d     = sel_fp;
        out_sel_d    = gnt_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
      out_rd_q     <= '0;
      out_fp_q     <= 1'b0;
      out_sel_q    <= SEL_DEFAULT;
      for (int i = 0; i < NUM_UNITS; i++) cnt_q[i] <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
      out_rd_q     <= out_rd_d;
      out_fp_q     <= out_fp_d;
      out_sel_q    <= out_sel_d;
      for (int i = 0; i < NUM_UNITS; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_result_o = out_result_q;
  assign out_rd_o     = out_rd_q;
  assign out_fp_o     = out_fp_q;
  assign out_sel_o    = out_sel_q;

endmodule

// File: tb/tb_fu_result_arbiter.sv
// Randomized and directed bench for fu_result_arbiter with a queue-based requester
// model and a rule-level reference of the arbitration and output slot.
module tb_fu_result_arbiter;
  localparam int NU  = 10;
  localparam int DW  = 32;
  localparam int RW  = 5;
  localparam int LIM = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic [NU-1:0]     vld;
  logic [NU-1:0]     req_ready_o;
  logic [NU*DW-1:0]  res_flat;
  logic [NU*RW-1:0]  rd_flat;
  logic [NU-1:0]     fp_vec;
  logic              out_valid_o;
  logic              out_ready;
  logic [DW-1:0]     out_result_o;
  logic [RW-1:0]     out_rd_o;
  logic              out_fp_o;
  logic [3:0]        out_sel_o;

  fu_result_arbiter #(.NUM_UNITS(NU), .DATA_W(DW), .RD_W(RW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(vld), .req_ready_o(req_ready_o),
    .req_result_i(res_flat), .req_rd_i(rd_flat), .req_fp_i(fp_vec),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready),
    .out_result_o(out_result_o), .out_rd_o(out_rd_o), .out_fp_o(out_fp_o),
    .out_sel_o(out_sel_o)
  );

  typedef struct packed {
    logic [DW-1:0] res;
    logic [RW-1:0] rd;
    logic          fp;
  } txn_t;

  txn_t pend [NU][$];

  // Reference state: output slot contents and per-unit denied-cycle counts.
  bit            m_valid;
  logic [DW-1:0] m_res;
  logic [RW-1:0] m_rd;
  logic          m_fp;
  int            m_sel;
  int            m_wait [NU];
  int            nchk = 0;
  int            nerr = 0;

  function automatic int pick(bit can);
    if (!can) return -1;
    for (int i = 0; i < NU; i++) if (vld[i] && m_wait[i] >= LIM) return i;
    for (int i = 0; i < NU; i++) if (vld[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 0; m_res = '0; m_rd = '0; m_fp = 0; m_sel = 7;
    for (int i = 0; i < NU; i++) m_wait[i] = 0;
  endtask

  task automatic push(input int u, input logic [DW-1:0] r, input logic [RW-1:0] d, input logic f);
    txn_t t;
    t.res = r; t.rd = d; t.fp = f;
    pend[u].push_back(t);
  endtask

  task automatic clear_pend();
    for (int i = 0; i < NU; i++) pend[i].delete();
  endtask

  task automatic drive();
    for (int i = 0; i < NU; i++) begin
      if (pend[i].size() > 0) begin
        vld[i] = 1'b1;
        res_flat[i*DW +: DW] = pend[i][0].res;
        rd_flat[i*RW +: RW]  = pend[i][0].rd;
        fp_vec[i]            = pend[i][0].fp;
      end else begin
        vld[i] = 1'b0;
        res_flat[i*DW +: DW] = $urandom;
        rd_flat[i*RW +: RW]  = RW'($urandom);
        fp_vec[i]            = 1'($urandom);
      end
    end
  endtask

  // One clock: present requests, sample ready mid-cycle, then advance the reference.
  task automatic cycle(output logic [NU-1:0] obs, output logic [NU-1:0] exp);
    bit can;
    int g;
    drive();
    @(negedge clk);
    can = !m_valid || out_ready;
    g = pick(can);
    exp = (g >= 0) ? (NU'(1) << g) : '0;
    obs = req_ready_o;
    @(posedge clk);
    #1;
    for (int i = 0; i < NU; i++) begin
      if (!vld[i] || i == g) m_wait[i] = 0;
      else if (can) m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
    end
    if (can) begin
      if (g >= 0) begin
        m_valid = 1; m_res = pend[g][0].res; m_rd = pend[g][0].rd;
        m_fp = pend[g][0].fp; m_sel = g;
        void'(pend[g].pop_front());
      end else begin
        m_valid = 0;
      end
    end
  endtask

  task automatic drain();
    logic [NU-1:0] o, e;
    int left;
    out_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      left = 0;
      for (int i = 0; i < NU; i++) left += pend[i].size();
      if (left == 0 && !m_valid) break;
      cycle(o, e);
    end
  endtask

  task automatic test_reset();
    logic [NU-1:0] o, e;
    reset_n = 1'b0; out_ready = 1'b0;
    clear_pend(); drive();
    #12;
    nchk++; if (out_valid_o !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %b expected 0", out_valid_o); end
    nchk++; if (out_result_o !== '0) begin nerr++; $display("FAIL reset_result: got %h expected 0", out_result_o); end
    nchk++; if (out_rd_o !== '0 || out_fp_o !== 1'b0) begin nerr++; $display("FAIL reset_rd_fp: got %h/%b expected 0/0", out_rd_o, out_fp_o); end
    nchk++; if (out_sel_o !== 4'd7) begin nerr++; $display("FAIL reset_sel: got %0d expected 7", out_sel_o); end
    push(3, 32'h1234, 5'd3, 1'b0); drive(); #1;
    nchk++; if (req_ready_o !== '0) begin nerr++; $display("FAIL reset_ready: got %b expected 0", req_ready_o); end
    clear_pend(); drive();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle(o, e);
      nchk++; if (o !== '0 || out_valid_o !== 1'b0 || out_sel_o !== 4'd7) begin
        nerr++; $display("FAIL idle: ready=%b valid=%b sel=%0d expected 0/0/7", o, out_valid_o, out_sel_o);
      end
    end
  endtask

  task automatic test_single();
    logic [NU-1:0] o, e;
    out_ready = 1'b1;
    push(4, 32'h0000_0015, 5'd5, 1'b0);
    cycle(o, e);
    nchk++; if (o !== 10'b0000010000) begin nerr++; $display("FAIL single_ready: got %b expected 0000010000", o); end
    nchk++; if (out_valid_o !== 1'b1 || out_result_o !== 32'h15 || out_rd_o !== 5'd5 || out_fp_o !== 1'b0 || out_sel_o !== 4'd4) begin
      nerr++; $display("FAIL single_out: got v=%b r=%h rd=%0d fp=%b sel=%0d expected 1/15/5/0/4",
                       out_valid_o, out_result_o, out_rd_o, out_fp_o, out_sel_o);
    end
    cycle(o, e);
    nchk++; if (out_valid_o !== 1'b0 || out_result_o !== 32'h15) begin
      nerr++; $display("FAIL single_after: got v=%b r=%h expected 0/15", out_valid_o, out_result_o);
    end
  endtask

  task automatic test_priority();
    logic [NU-1:0] o, e;
    out_ready = 1'b1;
    push(2, 32'hAAAA_0002, 5'd2, 1'b1);
    push(6, 32'hBBBB_0006, 5'd6, 1'b0);
    cycle(o, e);
    nchk++; if (o !== 10'b0000000100 || out_sel_o !== 4'd2 || out_result_o !== 32'hAAAA_0002 || out_fp_o !== 1'b1) begin
      nerr++; $display("FAIL prio_first: ready=%b sel=%0d r=%h fp=%b expected 0000000100/2/aaaa0002/1", o, out_sel_o, out_result_o, out_fp_o);
    end
    cycle(o, e);
    nchk++; if (o !== 10'b0001000000 || out_valid_o !== 1'b1 || out_sel_o !== 4'd6 || out_result_o !== 32'hBBBB_0006) begin
      nerr++; $display("FAIL prio_second: ready=%b v=%b sel=%0d r=%h expected 0001000000/1/6/bbbb0006", o, out_valid_o, out_sel_o, out_result_o);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [NU-1:0] o, e;
    out_ready = 1'b1;
    push(3, 32'hC0C0_0003, 5'd13, 1'b0);
    cycle(o, e);
    out_ready = 1'b0;
    push(0, 32'h0000_D000, 5'd1, 1'b1);
    push(9, 32'h9000_0009, 5'd9, 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycle(o, e);
      nchk++; if (o !== '0 || out_valid_o !== 1'b1 || out_sel_o !== 4'd3 || out_result_o !== 32'hC0C0_0003 || out_rd_o !== 5'd13) begin
        nerr++; $display("FAIL bp_hold[%0d]: ready=%b v=%b sel=%0d r=%h rd=%0d expected 0/1/3/c0c00003/13",
                         k, o, out_valid_o, out_sel_o, out_result_o, out_rd_o);
      end
    end
    out_ready = 1'b1;
    cycle(o, e);
    nchk++; if (o !== 10'b0000000001 || out_sel_o !== 4'd0 || out_result_o !== 32'h0000_D000) begin
      nerr++; $display("FAIL bp_release: ready=%b sel=%0d r=%h expected 0000000001/0/0000d000", o, out_sel_o, out_result_o);
    end
    cycle(o, e);
    nchk++; if (o !== 10'b1000000000 || out_sel_o !== 4'd9) begin
      nerr++; $display("FAIL bp_second: ready=%b sel=%0d expected 1000000000/9", o, out_sel_o);
    end
    drain();
  endtask

  task automatic test_starve();
    logic [NU-1:0] o, e;
    int seq [7] = '{0, 0, 0, 0, 9, 0, 0};
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) push(0, 32'h100 + k, RW'(k), 1'b0);
    push(9, 32'h9999, 5'd31, 1'b1);
    for (int k = 0; k < 7; k++) begin
      cycle(o, e);
      nchk++; if (o !== (NU'(1) << seq[k]) || out_sel_o !== 4'(seq[k])) begin
        nerr++; $display("FAIL starve[%0d]: ready=%b sel=%0d expected unit %0d", k, o, out_sel_o, seq[k]);
      end
    end
    drain();
  endtask

  task automatic test_throughput();
    logic [NU-1:0] o, e;
    int sel_exp [3] = '{1, 3, 5};
    out_ready = 1'b1;
    push(1, 32'h1111_0001, 5'd11, 1'b0);
    push(3, 32'h3333_0003, 5'd13, 1'b1);
    push(5, 32'h5555_0005, 5'd15, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cycle(o, e);
      nchk++; if (out_valid_o !== 1'b1 || out_sel_o !== 4'(sel_exp[k])) begin
        nerr++; $display("FAIL thru[%0d]: v=%b sel=%0d expected 1/%0d", k, out_valid_o, out_sel_o, sel_exp[k]);
      end
    end
    cycle(o, e);
    nchk++; if (out_valid_o !== 1'b0 || out_result_o !== 32'h5555_0005 || out_sel_o !== 4'd5) begin
      nerr++; $display("FAIL thru_end: v=%b r=%h sel=%0d expected 0/55550005/5", out_valid_o, out_result_o, out_sel_o);
    end
  endtask

  task automatic test_random();
    logic [NU-1:0] o, e;
    for (int k = 0; k < 500; k++) begin
      for (int i = 0; i < NU; i++)
        if (pend[i].size() == 0 && $urandom_range(0, 9) < 3)
          push(i, $urandom, RW'($urandom), 1'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle(o, e);
      nchk++; if (o !== e) begin nerr++; $display("FAIL rnd_ready[%0d]: got %b expected %b", k, o, e); end
      nchk++; if (out_valid_o !== m_valid) begin nerr++; $display("FAIL rnd_valid[%0d]: got %b expected %b", k, out_valid_o, m_valid); end
      nchk++; if (out_result_o !== m_res || out_rd_o !== m_rd || out_fp_o !== m_fp || out_sel_o !== 4'(m_sel)) begin
        nerr++; $display("FAIL rnd_data[%0d]: got %h/%0d/%b/%0d expected %h/%0d/%b/%0d", k,
                         out_result_o, out_rd_o, out_fp_o, out_sel_o, m_res, m_rd, m_fp, m_sel);
      end
    end
    drain();
  endtask

  task automatic test_async_reset();
    logic [NU-1:0] o, e;
    out_ready = 1'b1;
    push(7, 32'hABCD_0007, 5'd7, 1'b1);
    cycle(o, e);
    out_ready = 1'b0;
    push(1, 32'h0101_0101, 5'd1, 1'b0);
    drive();
    #2;
    reset_n = 1'b0;
    #1;
    nchk++; if (out_valid_o !== 1'b0 || req_ready_o !== '0 || out_sel_o !== 4'd7 || out_result_o !== '0) begin
      nerr++; $display("FAIL async_reset: v=%b ready=%b sel=%0d r=%h expected 0/0/7/0", out_valid_o, req_ready_o, out_sel_o, out_result_o);
    end
    clear_pend(); drive();
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    out_ready = 1'b1;
    cycle(o, e);
    nchk++; if (out_valid_o !== 1'b0 || o !== '0) begin
      nerr++; $display("FAIL post_reset: v=%b ready=%b expected 0/0", out_valid_o, o);
    end
  endtask

  initial begin
    vld = '0; res_flat = '0; rd_flat = '0; fp_vec = '0;
    model_reset();
    test_reset();
    test_single();
    test_priority();
    test_backpressure();
    test_starve();
    test_throughput();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
